bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter driven by two push-button inputs, with per-digit BCD LED output and per-digit 7-segment (FND) output. It is the successor to the fixed three-digit cascaded counter: digit count, wrap/saturate mode and optional input debouncing are configurable. Button synchronisation, edge detection and signed carry/borrow status are handled internally. It sits between the board push buttons and the LED/FND pins.

---
 rtl/bcd_updown_counter.sv | 195 +++++++++++++++++++
 tb/tb_bcd_updown_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with push-button inputs, BCD LED and active-low 7-seg outputs.
// Optional per-button debounce filter enabled by defining BCD_CNT_DEBOUNCE_EN.
module bcd_updown_counter #(
  parameter int DIGITS     = 3,
  parameter bit WRAP       = 1'b1,
  parameter int DEB_CYCLES = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [1:0]            i_Push,
  input  logic                  i_Clr,
  output logic [4*DIGITS-1:0]   o_LED,
  output logic [7*DIGITS-1:0]   o_FND,
  output logic                  o_Carry,
  output logic                  o_Borrow
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] max_value();
    logic [W-1:0] r;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'd9;
    return r;
  endfunction

  localparam logic [W-1:0] MAX_VAL = max_value();

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [1:0]   sync1_r, sync2_r, edge_r;
  logic [1:0]   level_s, pulse_s;
  logic [W-1:0] count_r, next_count_s;
  logic         carry_r, borrow_r, carry_s, borrow_s;

  // Two-stage synchroniser for the asynchronous buttons.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= i_Push;
      sync2_r <= sync1_r;
    end
  end

`ifdef BCD_CNT_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [1:0]    filt_r;
  logic [DW-1:0] deb_cnt_r [2];

  // Filtered level follows the synchronised level only after DEB_CYCLES disagreeing edges in a row.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      filt_r       <= 2'b00;
      deb_cnt_r[0] <= '0;
      deb_cnt_r[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != filt_r[i]) begin
          if (deb_cnt_r[i] == DW'(DEB_CYCLES - 1)) begin
            filt_r[i]    <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  assign level_s = filt_r;
`else
  assign level_s = sync2_r;
`endif

  // Edge register: resets low so a button held through reset still yields one pulse.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      edge_r <= 2'b00;
    end else begin
      edge_r <= level_s;
    end
  end

  assign pulse_s = level_s & ~edge_r;

  // Next-count selection: clear, then simultaneous cancel, then up, then down.
  always_comb begin
    next_count_s = count_r;
    carry_s      = 1'b0;
    borrow_s     = 1'b0;
    if (i_Clr) begin
      next_count_s = '0;
    end else if (pulse_s == 2'b11) begin
      next_count_s = count_r;
    end else if (pulse_s[0]) begin
      if (count_r == MAX_VAL) begin
        carry_s      = 1'b1;
        next_count_s = WRAP ? '0 : count_r;
      end else begin
        next_count_s = bcd_inc(count_r);
      end
    end else if (pulse_s[1]) begin
      if (count_r == '0) begin
        borrow_s     = 1'b1;
        next_count_s = WRAP ? MAX_VAL : count_r;
      end else begin
        next_count_s = bcd_dec(count_r);
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // Count and status flag registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      count_r  <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      count_r  <= next_count_s;
      carry_r  <= carry_s;
      borrow_r <= borrow_s;
    end
  end

  assign o_LED    = count_r;
  assign o_Carry  = carry_r;
  assign o_Borrow = borrow_r;

  for (genvar k = 0; k < DIGITS; k++) begin : g_fnd
    assign o_FND[7*k +: 7] = seg_decode(count_r[4*k +: 4]);
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: one wrapping and one saturating 3-digit instance.
// With BCD_CNT_DEBOUNCE_EN defined only the debounce scenarios run.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  push = 2'b00;
  logic        clr = 1'b0;
  logic [11:0] led_w, led_s;
  logic [20:0] fnd_w, fnd_s;
  logic        carry_w, carry_s, borrow_w, borrow_s;
  int          tests = 0;
  int          fails = 0;

`ifdef BCD_CNT_DEBOUNCE_EN
  localparam int EXTRA = 16;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [20:0] FND_ZERO = {7'b1000000, 7'b1000000, 7'b1000000};
  localparam logic [20:0] FND_457  = {7'b0011001, 7'b0010010, 7'b1111000};

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1), .DEB_CYCLES(16)) dut_w (
    .i_Clk(clk), .i_Rst(rst_n), .i_Push(push), .i_Clr(clr),
    .o_LED(led_w), .o_FND(fnd_w), .o_Carry(carry_w), .o_Borrow(borrow_w)
  );

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0), .DEB_CYCLES(16)) dut_s (
    .i_Clk(clk), .i_Rst(rst_n), .i_Push(push), .i_Clr(clr),
    .o_LED(led_s), .o_FND(fnd_s), .o_Carry(carry_s), .o_Borrow(borrow_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns just after the edge on which the count updates.
  task automatic press(input logic [1:0] b);
    push = b;
    repeat (2 + EXTRA) @(negedge clk);
    push = 2'b00;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (2 + EXTRA) @(negedge clk);
  endtask

  task automatic step(input logic [1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      press(b);
      settle();
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_led", led_w, 12'h000);
    chk("reset_fnd", fnd_w, FND_ZERO);
    chk("reset_flags", {carry_w, borrow_w, carry_s, borrow_s}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef BCD_CNT_DEBOUNCE_EN
    push = 2'b01;
    repeat (10) @(negedge clk);
    push = 2'b00;
    repeat (40) @(negedge clk);
    chk("deb_glitch", led_w, 12'h000);

    push = 2'b01;
    repeat (18) @(negedge clk);
    chk("deb_before_19", led_w, 12'h000);
    @(negedge clk);
    chk("deb_edge_19", led_w, 12'h001);
    @(negedge clk);
    push = 2'b00;
    repeat (40) @(negedge clk);
    chk("deb_one_step", led_w, 12'h001);
    step(2'b01, 2);
    chk("deb_steps", led_s, 12'h003);
`else
    // Ripple up 099 -> 100 with latency check
    step(2'b01, 99);
    chk("up_099", led_w, 12'h099);
    push = 2'b01;
    repeat (2) @(negedge clk);
    chk("up_latency_edge2", led_w, 12'h099);
    push = 2'b00;
    @(negedge clk);
    chk("up_ripple_100", led_w, 12'h100);
    settle();

    press(2'b10);
    chk("down_ripple_099", led_s, 12'h099);
    settle();

    step(2'b01, 900);
    chk("up_999", {led_w, led_s}, 24'h999999);
    press(2'b01);
    chk("wrap_led", led_w, 12'h000);
    chk("sat_led", led_s, 12'h999);
    chk("carry_pulse", {carry_w, carry_s}, 2'b11);
    @(negedge clk);
    chk("carry_one_cycle", {carry_w, carry_s}, 2'b00);
    settle();

    clear();
    chk("clear", {led_w, led_s}, 24'h000000);
    press(2'b10);
    chk("sat_zero", led_s, 12'h000);
    chk("wrap_under", led_w, 12'h999);
    chk("borrow_pulse", {borrow_w, borrow_s}, 2'b11);
    @(negedge clk);
    chk("borrow_one_cycle", {borrow_w, borrow_s}, 2'b00);
    settle();

    // Simultaneous presses cancel
    clear();
    step(2'b01, 250);
    chk("at_250", led_w, 12'h250);
    press(2'b11);
    chk("simul_led", {led_w, led_s}, 24'h250250);
    chk("simul_flags", {carry_w, borrow_w, carry_s, borrow_s}, 4'b0000);
    settle();

    // Clear wins over a coincident up pulse
    clear();
    step(2'b01, 998);
    chk("at_998", led_w, 12'h998);
    push = 2'b01;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    push = 2'b00;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_vs_up", led_w, 12'h000);
    chk("clr_no_carry", carry_w, 1'b0);
    settle();

    // Holding a button yields exactly one step
    step(2'b01, 5);
    push = 2'b01;
    repeat (2) @(negedge clk);
    chk("hold_edge2", led_w, 12'h005);
    @(negedge clk);
    chk("hold_edge3", led_w, 12'h006);
    chk("hold_fnd_d0", fnd_w[6:0], 7'b0000010);
    repeat (47) @(negedge clk);
    push = 2'b00;
    settle();
    chk("hold_one_step", led_w, 12'h006);

    // Asynchronous reset mid-count
    step(2'b01, 451);
    chk("at_457", led_w, 12'h457);
    chk("fnd_457", fnd_w, FND_457);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", led_w, 12'h000);
    chk("async_rst_fnd", fnd_w, FND_ZERO);
    chk("async_rst_flags", {carry_w, borrow_w}, 2'b00);

    // Button held across reset release gives one step
    push = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_press_edge2", led_w, 12'h000);
    @(negedge clk);
    chk("rst_press_edge3", led_w, 12'h001);
    repeat (5) @(negedge clk);
    push = 2'b00;
    settle();
    chk("rst_press_once", led_s, 12'h001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
